// File: rtl/square_share_arbiter.sv
// Round-robin arbiter in front of a two-stage pipeline that shares one OP_W x OP_W squarer.
// Results are tagged with the requester index and honour downstream backpressure.
module square_share_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned OP_W    = 7,
  parameter int unsigned ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  input  logic [NUM_REQ*OP_W-1:0] req_operand_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic [ID_W-1:0]         res_id_o,
  output logic [2*OP_W-1:0]       res_square_o
);

  localparam int unsigned SqW = 2 * OP_W;

  logic            a_valid_q, a_valid_d;
  logic [OP_W-1:0] a_op_q, a_op_d;
  logic [ID_W-1:0] a_id_q, a_id_d;

  logic            b_valid_q, b_valid_d;
  logic [SqW-1:0]  b_sq_q, b_sq_d;
  logic [ID_W-1:0] b_id_q, b_id_d;

  logic [ID_W-1:0] ptr_q, ptr_d;

  logic            b_adv, a_adv;
  logic            grant_any, grant;
  logic [ID_W-1:0] grant_id, cand;
  logic [SqW-1:0]  a_sq;

  // Requester visited k steps after the pointer, wrapping at NUM_REQ.
  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] ptr, input int unsigned k);
    return ID_W'((32'(ptr) + k) % NUM_REQ);
  endfunction

  assign b_adv = !b_valid_q || res_ready_i;
  assign a_adv = !a_valid_q || b_adv;

  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = rr_idx(ptr_q, k);
      if (!grant_any && req_valid_i[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
  end

  assign grant = a_adv && grant_any;

  always_comb begin
    req_ready_o = '0;
    if (grant) begin
      req_ready_o[grant_id] = 1'b1;
    end
  end

  assign a_sq = SqW'(a_op_q) * SqW'(a_op_q);

  always_comb begin
    a_valid_d = a_valid_q;
    a_op_d    = a_op_q;
    a_id_d    = a_id_q;
    ptr_d     = ptr_q;
    b_valid_d = b_valid_q;
    b_sq_d    = b_sq_q;
    b_id_d    = b_id_q;

    if (grant) begin
      a_valid_d = 1'b1;
      a_op_d    = req_operand_i[32'(grant_id) * OP_W +: OP_W];
      a_id_d    = grant_id;
      ptr_d     = grant_id;
    end else if (a_adv) begin
      a_valid_d = 1'b0;
    end

    if (b_adv) begin
      b_valid_d = a_valid_q;
      b_sq_d    = a_sq;
      b_id_d    = a_id_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid_q <= 1'b0;
      a_op_q    <= '0;
      a_id_q    <= '0;
      b_valid_q <= 1'b0;
      b_sq_q    <= '0;
      b_id_q    <= '0;
      ptr_q     <= ID_W'(NUM_REQ - 1);
    end else begin
      a_valid_q <= a_valid_d;
      a_op_q    <= a_op_d;
      a_id_q    <= a_id_d;
      b_valid_q <= b_valid_d;
      b_sq_q    <= b_sq_d;
      b_id_q    <= b_id_d;
      ptr_q     <= ptr_d;
    end
  end

  assign res_valid_o  = b_valid_q;
  assign res_id_o     = b_id_q;
  assign res_square_o = b_sq_q;

`ifndef SYNTHESIS
  a_grant_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready_o));

  a_res_hold : assert property (@(posedge clk) disable iff (rst)
    res_valid_o && !res_ready_i |=> res_valid_o && $stable(res_id_o) && $stable(res_square_o));
`endif

endmodule
